// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH independent programmable clock-enable dividers.
// Each channel divides clk_in by a shadowed ratio. It produces a low-biased
// square wave (clk_out) and a one-cycle strobe on the last cycle of every
// period (tick).
// A new ratio is only adopted at a period boundary, while the channel is
// disabled or stopped, or on a global sync pulse. Because of this, a period
// is never truncated or stretched by a mid-period ratio change.
module clock_divider_multi #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync,
  input  logic [NUM_CH*WIDTH-1:0] ratio,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act_ratio;
    logic [WIDTH-1:0] req_ratio;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] ratio_nxt;
    logic             clk_nxt;
    logic             tick_nxt;
    logic             busy_nxt;

    assign req_ratio = ratio[i*WIDTH +: WIDTH];

    // Next count/ratio, with outputs derived from the next count so they line up with cnt
    always_comb begin
      cnt_nxt   = '0;
      ratio_nxt = act_ratio;
      clk_nxt   = 1'b0;
      tick_nxt  = 1'b0;
      if (!en[i] || sync || (act_ratio == '0)) begin
        cnt_nxt   = '0;
        ratio_nxt = req_ratio;
      end else if (cnt == (act_ratio - ONE)) begin
        cnt_nxt   = '0;
        ratio_nxt = req_ratio;
      end else begin
        cnt_nxt   = cnt + ONE;
        ratio_nxt = act_ratio;
      end
      if (en[i] && !sync && (ratio_nxt != '0)) begin
        clk_nxt  = (cnt_nxt >= (ratio_nxt - (ratio_nxt >> 1)));
        tick_nxt = (cnt_nxt == (ratio_nxt - ONE));
      end
      busy_nxt = (ratio_nxt != req_ratio);
    end

    // Channel state and registered outputs, cleared asynchronously by reset
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt        <= '0;
        act_ratio  <= '0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
        busy[i]    <= 1'b0;
      end else begin
        cnt        <= cnt_nxt;
        act_ratio  <= ratio_nxt;
        clk_out[i] <= clk_nxt;
        tick[i]    <= tick_nxt;
        busy[i]    <= busy_nxt;
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed self-checking bench for clock_divider_multi
// (NUM_CH=4, WIDTH=8). Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point.
module tb_clock_divider_multi;

  logic        clk_in;
  logic        rst_n;
  logic [3:0]  en;
  logic        sync;
  logic [31:0] ratio;
  logic [3:0]  clk_out;
  logic [3:0]  tick;
  logic [3:0]  busy;

  int compared;
  int mismatched;

  clock_divider_multi #(.NUM_CH(4), .WIDTH(8)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .sync    (sync),
    .ratio   (ratio),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  // 10-unit free-running system clock
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic applyStimulus(input logic [3:0] e, input logic s, input logic [31:0] r);
    en    = e;
    sync  = s;
    ratio = r;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps n cycles; bit k of each pattern is the expected value after step k+1
  task automatic checkPattern(input string tag, input int ch, input int n,
                              input logic [31:0] clk_pat, input logic [31:0] tick_pat,
                              input logic [31:0] busy_pat);
    for (int k = 0; k < n; k++) begin
      waitCycles(1);
      checkOutput($sformatf("%s_clk[%0d]", tag, k), 32'(clk_out[ch]), 32'(clk_pat[k]));
      checkOutput($sformatf("%s_tick[%0d]", tag, k), 32'(tick[ch]), 32'(tick_pat[k]));
      checkOutput($sformatf("%s_busy[%0d]", tag, k), 32'(busy[ch]), 32'(busy_pat[k]));
    end
  endtask

  initial begin
    int hit;
    int first_tick;
    int last_tick;
    int tick_count;
    int bad_gaps;
    int high_count;
    int first_high;

    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    applyStimulus(4'b0000, 1'b0, 32'h0);
    waitCycles(2);
    checkOutput("reset_clk", 32'(clk_out), 32'h0);
    checkOutput("reset_tick", 32'(tick), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    $display("[TB] ratio 4/5/1/0 on channel 0");
    applyStimulus(4'b0001, 1'b0, 32'h4);
    checkPattern("r4", 0, 8, 32'b11001100, 32'b10001000, 32'h0);
    applyStimulus(4'b0001, 1'b0, 32'h5);
    checkPattern("r5", 0, 10, 32'b1100011000, 32'b1000010000, 32'h0);
    applyStimulus(4'b0001, 1'b0, 32'h1);
    checkPattern("r1", 0, 4, 32'h0, 32'b1111, 32'h0);
    applyStimulus(4'b0001, 1'b0, 32'h0);
    checkPattern("r0", 0, 4, 32'h0, 32'h0, 32'h0);

    $display("[TB] ratio 6 changed to 3 mid-period");
    applyStimulus(4'b0001, 1'b0, 32'h6);
    checkPattern("r6", 0, 3, 32'h0, 32'h0, 32'h0);
    applyStimulus(4'b0001, 1'b0, 32'h3);
    checkPattern("r6to3", 0, 9, 32'b100100111, 32'b100100100, 32'b000000111);

    $display("[TB] four channels 3/4/5/7 with sync");
    applyStimulus(4'b1111, 1'b0, 32'h07050403);
    waitCycles(int'($urandom_range(5, 20)));
    applyStimulus(4'b1111, 1'b1, 32'h07050403);
    waitCycles(1);
    applyStimulus(4'b1111, 1'b0, 32'h07050403);
    checkOutput("sync_t0_clk", 32'(clk_out), 32'h0);
    checkOutput("sync_t0_tick", 32'(tick), 32'h0);
    checkOutput("sync_t0_busy", 32'(busy), 32'h0);
    waitCycles(1);
    checkOutput("sync_t1_clk", 32'(clk_out), 32'h0);
    checkOutput("sync_t1_tick", 32'(tick), 32'h0);
    waitCycles(1);
    checkOutput("sync_t2_clk", 32'(clk_out), 32'b0011);
    checkOutput("sync_t2_tick", 32'(tick), 32'b0001);
    waitCycles(1);
    checkOutput("sync_t3_clk", 32'(clk_out), 32'b0110);
    checkOutput("sync_t3_tick", 32'(tick), 32'b0010);
    hit = -1;
    for (int t = 4; t < 600; t++) begin
      waitCycles(1);
      if (tick == 4'hF) begin
        hit = t;
        break;
      end
    end
    checkOutput("all_tick_cycle", 32'(hit), 32'd419);
    checkOutput("all_tick_clk", 32'(clk_out), 32'hF);

    // Sync on the same edge as a wrap on every channel
    applyStimulus(4'b1111, 1'b1, 32'h07050403);
    waitCycles(1);
    applyStimulus(4'b1111, 1'b0, 32'h07050403);
    checkOutput("sync_wrap_clk", 32'(clk_out), 32'h0);
    checkOutput("sync_wrap_tick", 32'(tick), 32'h0);
    waitCycles(2);
    checkOutput("sync_wrap_t2_clk", 32'(clk_out), 32'b0011);
    checkOutput("sync_wrap_t2_tick", 32'(tick), 32'b0001);

    $display("[TB] ratio 255 on channel 3");
    applyStimulus(4'b0000, 1'b0, 32'hFF050403);
    waitCycles(1);
    checkOutput("dis_clk", 32'(clk_out), 32'h0);
    checkOutput("dis_tick", 32'(tick), 32'h0);
    checkOutput("dis_busy", 32'(busy), 32'h0);
    applyStimulus(4'b1000, 1'b0, 32'hFF050403);
    first_tick = -1;
    last_tick  = -1;
    tick_count = 0;
    bad_gaps   = 0;
    high_count = 0;
    first_high = -1;
    for (int k = 1; k <= 2804; k++) begin
      waitCycles(1);
      if (tick[3]) begin
        tick_count++;
        if (first_tick < 0) first_tick = k;
        else if (k - last_tick != 255) bad_gaps++;
        last_tick = k;
      end
      if (clk_out[3]) begin
        high_count++;
        if (first_high < 0) first_high = k;
      end
    end
    checkOutput("r255_first_tick", 32'(first_tick), 32'd254);
    checkOutput("r255_last_tick", 32'(last_tick), 32'd2804);
    checkOutput("r255_tick_count", 32'(tick_count), 32'd11);
    checkOutput("r255_bad_gaps", 32'(bad_gaps), 32'd0);
    checkOutput("r255_high_count", 32'(high_count), 32'd1397);
    checkOutput("r255_first_high", 32'(first_high), 32'd128);

    $display("[TB] enable drop and re-enable on channel 2");
    applyStimulus(4'b1100, 1'b0, 32'hFF050403);
    waitCycles(2);
    checkOutput("en2_cnt2_clk", 32'(clk_out[2]), 32'h0);
    waitCycles(1);
    checkOutput("en2_cnt3_clk", 32'(clk_out[2]), 32'h1);
    applyStimulus(4'b1000, 1'b0, 32'hFF050403);
    waitCycles(1);
    checkOutput("en2_off_clk", 32'(clk_out[2]), 32'h0);
    checkOutput("en2_off_tick", 32'(tick[2]), 32'h0);
    waitCycles(2);
    checkOutput("en2_off3_clk", 32'(clk_out[2]), 32'h0);
    applyStimulus(4'b1100, 1'b0, 32'hFF050403);
    checkPattern("reen", 2, 5, 32'b01100, 32'b01000, 32'h0);

    $display("[TB] asynchronous reset mid-period");
    applyStimulus(4'b1100, 1'b0, 32'h64050403);
    waitCycles(1);
    checkOutput("pre_reset_busy3", 32'(busy[3]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_clk", 32'(clk_out), 32'h0);
    checkOutput("async_reset_tick", 32'(tick), 32'h0);
    checkOutput("async_reset_busy", 32'(busy), 32'h0);
    waitCycles(1);
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("post_reset_load_clk", 32'(clk_out), 32'h0);
    checkOutput("post_reset_load_busy", 32'(busy), 32'h0);
    waitCycles(3);
    checkOutput("post_reset_cnt3_clk", 32'(clk_out), 32'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- N-channel programmable clock divider that generates per-channel divided clock-enable waveforms and a one-cycle period tick from a single clk_in.
- Extends the single-channel divider in four ways: parametrised ratio width, a per-channel enable, shadowed ratio updates that never produce a short period, and a global phase-sync input.
- Sits between the board oscillator and the CPU/peripheral clock-enable consumers (CPU step, UART baud, LED scan).

Parameters:
- NUM_CH, 4, number of independent divider channels (1-16).
- WIDTH, 8, bit width of each ratio field and each channel counter.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  NUM_CH  per-channel run enable.
- sync  input  1  one-cycle pulse; restarts all enabled channels in phase.
- ratio  input  NUM_CH*WIDTH  requested division ratio; channel i uses bits [i*WIDTH +: WIDTH].
- clk_out  output  NUM_CH  divided waveform per channel (registered).
- tick  output  NUM_CH  one-cycle strobe on the last cycle of each period (registered).
- busy  output  NUM_CH  high while the channel's active ratio differs from its requested ratio (update pending).

Behaviour:
- Reset: cnt, act_ratio, clk_out, tick and busy are all 0 on every channel.
- Per channel, R = act_ratio (the shadow register); cnt counts 0..R-1 and wraps to 0.
- Registered outputs:
  - In the cycle where the cnt register equals k, clk_out = 1 iff k >= R-(R>>1), and tick = 1 iff k == R-1.
  - Both outputs are computed from the next-count value, so they align with cnt with no added latency.
- Duty cycle: low for ceil(R/2) cycles, then high for floor(R/2) cycles. Odd R is low-biased.
- Ratio load points: ratio[i] is copied into act_ratio only at one of these:
  - the wrap point (cnt == R-1 → 0);
  - while en[i] == 0;
  - while R == 0;
  - on sync.
- Ratio changes mid-period therefore never truncate or stretch the current period.
- busy[i] = (act_ratio != ratio[i]), registered.
- R == 0: the channel is stopped.
  - cnt is held at 0; clk_out = 0; tick = 0.
  - A new nonzero ratio is loaded on the next cycle and counting starts from 0.
- R == 1: tick = 1 every cycle; clk_out = 0 constantly; cnt stays 0.
- R == 2^WIDTH-1: the counter must not overflow. The wrap compare uses full WIDTH arithmetic with no +1 carry loss.
- en[i] low:
  - Next cycle: cnt = 0, clk_out = 0, tick = 0.
  - act_ratio tracks ratio[i].
- en[i] rising: the first enabled cycle has cnt = 0, so the first period is complete.
- sync high:
  - Next cycle, every enabled channel has cnt = 0, clk_out = 0, tick = 0, and act_ratio = ratio[i].
  - sync overrides a coincident wrap on the same cycle. No tick is emitted for the interrupted period.
  - Disabled channels ignore sync.
- Channels are fully independent apart from sync. No combinational path runs from any input to any output.
- Reset asserted mid-operation: all state clears immediately (asynchronous).
- After rst_n deasserts, act_ratio loads on the first clock because R == 0.

Test Plan:
- NUM_CH=1, ratio=4, en=1 after reset → after one load cycle, clk_out repeats 0,0,1,1; tick high on every 4th cycle, coincident with the second high cycle.
- ratio=5 → clk_out repeats 0,0,0,1,1; tick period 5; ratio=1 → tick constant 1, clk_out constant 0; ratio=0 → both outputs 0.
- Running at ratio=6, change ratio to 3 at cnt=2:
  - busy goes high.
  - The current period completes at 6 cycles, then 3-cycle periods follow.
  - busy clears on the cycle after the wrap.
- NUM_CH=4, ratios 3/4/5/7, random start; pulse sync → all four clk_out are low with cnt=0 on the same cycle. Their ticks next coincide 420 cycles later.
- WIDTH=8, ratio=255 → tick period exactly 255 cycles, clk_out low 128 / high 127, no overflow over 10 periods.
- Deassert en[2] mid-period, then reassert 3 cycles later → outputs go low on the next cycle; on re-enable a full-length period starts with cnt=0. Assert rst_n low mid-period → all outputs go 0 asynchronously.
